// File: rtl/unbinder.sv
// Purpose: undo cyclic-shift binding; out[i] = in[(i - s) mod HV_DIM] (left rotation by s).
// Latency: 1 enabled cycle for s=0, else 1 + ceil(s/STEP) enabled cycles from accept to done.
// Backpressure: none; requests during ROT are dropped, en=0 freezes every register.
module unbinder #(
  parameter int HV_DIM  = 1024,
  parameter int STEP    = 8,
  parameter int SHIFT_W = $clog2(HV_DIM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start_unbinding,
  input  logic [SHIFT_W-1:0] shift_amt,
  input  logic [HV_DIM-1:0]  bound_hv,
  output logic               busy,
  output logic               done,
  output logic [HV_DIM-1:0]  unbound_hv
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROT  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // One bit wider than the shift so HV_DIM itself is representable for the wrap test.
  localparam logic [SHIFT_W:0]   DIM_X  = (SHIFT_W+1)'(HV_DIM);
  localparam logic [SHIFT_W-1:0] STEP_X = SHIFT_W'(STEP);

  state_t             state;
  state_t             state_nxt;
  logic [HV_DIM-1:0]  work;
  logic [HV_DIM-1:0]  work_rot;
  logic [SHIFT_W-1:0] rem;
  logic [SHIFT_W-1:0] k;
  logic [SHIFT_W-1:0] s_eff;
  logic [SHIFT_W:0]   shift_x;
  logic               accept;
  logic               last_step;

  // Fold shift amounts >= HV_DIM back into range (only reachable for non-power-of-two HV_DIM).
  always_comb begin
    shift_x = {1'b0, shift_amt};
    if (shift_x < DIM_X) begin
      s_eff = shift_amt;
    end else begin
      s_eff = SHIFT_W'(shift_x - DIM_X);
    end
  end

  // Per-cycle step size and request qualification.
  always_comb begin
    last_step = (rem <= STEP_X);
    k         = last_step ? rem : STEP_X;
    accept    = start_unbinding && ((state == S_IDLE) || (state == S_DONE));
  end

  // Bounded rotator: fan-in limited to STEP+1 constant rotations selected by k.
  always_comb begin
    work_rot = work;
    for (int j = 1; j <= STEP; j++) begin
      if (k == SHIFT_W'(j)) begin
        work_rot = (work << j) | (work >> (HV_DIM - j));
      end
    end
  end

  // State register; en=0 freezes the FSM, rst wins over en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else if (en) begin
      state <= state_nxt;
    end
  end

  // Next-state logic; DONE accepts a new request directly for back-to-back operation.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_nxt = (s_eff == '0) ? S_DONE : S_ROT;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_ROT: begin
        if (last_step) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded purely from the state register.
  always_comb begin
    busy = (state == S_ROT);
    done = (state == S_DONE);
  end

  // Datapath: capture on accept, rotate in ROT, publish the result on the final step.
  always_ff @(posedge clk) begin
    if (rst) begin
      work       <= '0;
      rem        <= '0;
      unbound_hv <= '0;
    end else if (en) begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (s_eff == '0) begin
              unbound_hv <= bound_hv;
            end else begin
              work <= bound_hv;
              rem  <= s_eff;
            end
          end
        end
        S_ROT: begin
          work <= work_rot;
          rem  <= rem - k;
          if (last_step) begin
            unbound_hv <= work_rot;
          end
        end
        default: begin
          work <= work;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unbinder.sv
module tb_unbinder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          en;

  logic          s_start;
  logic [3:0]    s_shift;
  logic [15:0]   s_hv;
  logic          s_busy;
  logic          s_done;
  logic [15:0]   s_out;

  logic          b_start;
  logic [9:0]    b_shift;
  logic [1023:0] b_hv;
  logic          b_busy;
  logic          b_done;
  logic [1023:0] b_out;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1023:0] val;
    int            lat;
    int            busy_cyc;
  } exp_t;

  exp_t sb[$];

  unbinder #(.HV_DIM(16), .STEP(4)) u_small (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .start_unbinding (s_start),
    .shift_amt       (s_shift),
    .bound_hv        (s_hv),
    .busy            (s_busy),
    .done            (s_done),
    .unbound_hv      (s_out)
  );

  unbinder #(.HV_DIM(1024), .STEP(8)) u_big (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .start_unbinding (b_start),
    .shift_amt       (b_shift),
    .bound_hv        (b_hv),
    .busy            (b_busy),
    .done            (b_done),
    .unbound_hv      (b_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1023:0] rotr1024(input logic [1023:0] x, input int s);
    return (x >> s) | (x << (1024 - s));
  endfunction

  function automatic logic [1023:0] rand1024();
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Issue one request to the 16-bit unit, wait for done, compare against the scoreboard.
  // stall_at > 0 drops en for two cycles starting at that cycle; pulse re-asserts start in ROT.
  task automatic run_small(input logic [15:0] hv, input logic [3:0] s, input int stall_at,
                           input bit pulse, input string tag);
    exp_t        e;
    exp_t        g;
    logic [15:0] r;
    int          lat;
    int          busy_n;
    int          stall;
    stall = (stall_at > 0) ? 2 : 0;
    r = (s == 4'd0) ? hv : ((hv << s) | (hv >> (16 - s)));
    e.val      = {1008'b0, r};
    e.lat      = ((s == 4'd0) ? 1 : 1 + (int'(s) + 3) / 4) + stall;
    e.busy_cyc = ((s == 4'd0) ? 0 : (int'(s) + 3) / 4) + stall;
    s_hv    = hv;
    s_shift = s;
    s_start = 1'b1;
    tick();
    sb.push_back(e);
    s_start = 1'b0;
    s_hv    = 16'($urandom);
    s_shift = 4'($urandom);
    lat    = 1;
    busy_n = 0;
    while (!s_done && lat < 300) begin
      if (s_busy) busy_n++;
      en      = !(stall_at > 0 && (lat == stall_at || lat == stall_at + 1));
      s_start = pulse && (lat == 2);
      tick();
      lat++;
    end
    en      = 1'b1;
    s_start = 1'b0;
    g = sb.pop_front();
    chk({tag, "_done"}, 1024'(s_done), 1024'(1));
    chk({tag, "_lat"},  1024'(lat), 1024'(g.lat));
    chk({tag, "_busy"}, 1024'(busy_n), 1024'(g.busy_cyc));
    chk({tag, "_val"},  {1008'b0, s_out}, g.val);
  endtask

  // Round trip on the 1024-bit unit: feed rotr(level, s), expect level back.
  task automatic run_big(input logic [1023:0] level, input int s, input string tag);
    exp_t e;
    exp_t g;
    int   lat;
    e.val      = level;
    e.lat      = 1 + (s + 7) / 8;
    e.busy_cyc = (s + 7) / 8;
    b_hv    = rotr1024(level, s);
    b_shift = 10'(s);
    b_start = 1'b1;
    tick();
    sb.push_back(e);
    b_start = 1'b0;
    b_hv    = rand1024();
    chk({tag, "_accepted"}, 1024'(b_busy), 1024'(1));
    lat = 1;
    while (!b_done && lat < 400) begin
      tick();
      lat++;
    end
    g = sb.pop_front();
    chk({tag, "_done"}, 1024'(b_done), 1024'(1));
    chk({tag, "_lat"},  1024'(lat), 1024'(g.lat));
    chk({tag, "_val"},  b_out, g.val);
  endtask

  initial begin
    logic [1023:0] lv1;
    logic [1023:0] lv2;
    int            done_n;

    // Reset with garbage on every input.
    rst     = 1'b1;
    en      = 1'($urandom);
    s_start = 1'b1;
    s_shift = 4'($urandom);
    s_hv    = 16'($urandom);
    b_start = 1'b1;
    b_shift = 10'($urandom);
    b_hv    = rand1024();
    tick();
    s_start = 1'($urandom);
    tick();
    chk("rst_busy", 1024'(s_busy), 1024'(0));
    chk("rst_done", 1024'(s_done), 1024'(0));
    chk("rst_out",  {1008'b0, s_out}, 1024'(0));
    chk("rst_big_out", b_out, 1024'(0));

    rst     = 1'b0;
    en      = 1'b1;
    s_start = 1'b0;
    b_start = 1'b0;
    done_n  = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (s_done || b_done) done_n++;
    end
    chk("no_spurious_done", 1024'(done_n), 1024'(0));

    // Directed cases, issued back to back.
    run_small(16'hA5C3, 4'd0,  0, 1'b0, "zero");
    run_small(16'h0001, 4'd10, 0, 1'b0, "s10");
    run_small(16'h0001, 4'd4,  0, 1'b0, "s4");
    run_small(16'hBEEF, 4'd15, 0, 1'b0, "s15");
    run_small(16'h8001, 4'd1,  0, 1'b0, "s1");
    run_small(16'h1234, 4'd0,  0, 1'b0, "zero_b2b");
    run_small(16'h0001, 4'd10, 2, 1'b0, "stall");
    run_small(16'h0001, 4'd10, 0, 1'b1, "ignore");
    run_small(16'h00F3, 4'd7,  0, 1'b0, "s7");

    // Reset on the second ROT cycle.
    tick();
    s_hv    = 16'h0001;
    s_shift = 4'd10;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 1024'(s_busy), 1024'(0));
    chk("midrst_done", 1024'(s_done), 1024'(0));
    chk("midrst_out",  {1008'b0, s_out}, 1024'(0));
    run_small(16'h0001, 4'd10, 0, 1'b0, "after_rst");

    // Wide round trips, back to back.
    lv1 = rand1024();
    lv2 = rand1024();
    run_big(lv1, 3,    "rt1_3");
    run_big(lv1, 1023, "rt1_1023");
    run_big(lv2, 3,    "rt2_3");
    run_big(lv2, 1023, "rt2_1023");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
